// File: rtl/cfi_log_batcher_pkg.sv
// Shared types for the CFI log batcher.
//   cfi_log_t          : one filtered control-flow log entry
//   cfi_batch_state_e  : batcher FSM states (COLLECT / PRESENT)
package cfi_log_batcher_pkg;

  typedef struct packed {
    logic [1:0]  kind;
    logic [31:0] pc;
    logic [31:0] target;
  } cfi_log_t;

  typedef enum logic {
    CFI_BATCH_COLLECT = 1'b0,
    CFI_BATCH_PRESENT = 1'b1
  } cfi_batch_state_e;

endpackage

// File: rtl/cfi_log_batcher_compactor.sv
// Combinational compactor: gathers the valid commit-port logs into the low
// slots of packed_logs in ascending port order and reports how many there are.
// Ports:
//   logs        in  per-port logs
//   valid       in  per-port valid
//   packed_logs out valid logs packed from slot 0 upward (unused slots 0)
//   count       out number of valid logs (popcount of valid)
module cfi_log_compactor
  import cfi_log_batcher_pkg::*;
#(
  parameter int unsigned NR_COMMIT_PORTS = 2,
  localparam int unsigned CW = $clog2(NR_COMMIT_PORTS + 1)
) (
  input  cfi_log_t [NR_COMMIT_PORTS-1:0] logs,
  input  logic     [NR_COMMIT_PORTS-1:0] valid,
  output cfi_log_t [NR_COMMIT_PORTS-1:0] packed_logs,
  output logic     [CW-1:0]              count
);

  always_comb begin
    int k;
    packed_logs = '0;
    k = 0;
    for (int i = 0; i < int'(NR_COMMIT_PORTS); i++) begin
      if (valid[i]) begin
        // Constant-index select avoids a variable index of mismatched width.
        for (int j = 0; j < int'(NR_COMMIT_PORTS); j++) begin
          if (j == k) packed_logs[j] = logs[i];
        end
        k++;
      end
    end
    count = CW'(k);
  end

endmodule

// File: rtl/cfi_log_batcher.sv
// CFI log batcher: compacts up to NR_COMMIT_PORTS logs per cycle into a
// circular queue and hands them to the backend in batches of up to BATCH_SIZE
// over valid/ready. A batch is captured when full, on idle timeout or on flush.
// Optional build macro: CFI_BATCH_PERF_EN enables the two perf counters;
// without it perf_batches_o / perf_partial_o are tied to 0.
// Ports:
//   clk_i, rst_i (async, active-high)
//   log_i, log_valid_i   filtered logs from commit
//   flush_i              force emission of a partial batch
//   halt_o               stall commit (free slots < NR_COMMIT_PORTS)
//   batch_o, batch_count_o, batch_valid_o, batch_ready_i  batch handshake
//   usage_o              queue occupancy
//   drop_cnt_o           saturating count of logs dropped while halted
//   perf_batches_o, perf_partial_o  accepted batches / accepted partial batches
module cfi_log_batcher
  import cfi_log_batcher_pkg::*;
#(
  parameter int unsigned NR_COMMIT_PORTS = 2,
  parameter int unsigned QUEUE_DEPTH     = 8,
  parameter int unsigned BATCH_SIZE      = 4,
  parameter int unsigned FLUSH_TIMEOUT   = 64,
  localparam int unsigned OW = $clog2(QUEUE_DEPTH + 1),
  localparam int unsigned BW = $clog2(BATCH_SIZE + 1)
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  cfi_log_t [NR_COMMIT_PORTS-1:0] log_i,
  input  logic     [NR_COMMIT_PORTS-1:0] log_valid_i,
  input  logic                           flush_i,
  output logic                           halt_o,
  output cfi_log_t [BATCH_SIZE-1:0]      batch_o,
  output logic     [BW-1:0]              batch_count_o,
  output logic                           batch_valid_o,
  input  logic                           batch_ready_i,
  output logic     [OW-1:0]              usage_o,
  output logic     [7:0]                 drop_cnt_o,
  output logic     [31:0]                perf_batches_o,
  output logic     [31:0]                perf_partial_o
);

  localparam int unsigned PW = $clog2(QUEUE_DEPTH);
  localparam int unsigned CW = $clog2(NR_COMMIT_PORTS + 1);
  localparam int unsigned TW = (FLUSH_TIMEOUT > 1) ? $clog2(FLUSH_TIMEOUT) : 1;

  cfi_log_t                       q [QUEUE_DEPTH];
  logic [PW-1:0]                  wr_ptr, rd_ptr;
  logic [OW-1:0]                  occ, pushes, pops;
  logic [TW-1:0]                  tcnt;
  cfi_batch_state_e               state, state_next;
  cfi_log_t [NR_COMMIT_PORTS-1:0] packed_logs;
  logic [CW-1:0]                  push_cnt;
  logic [BW-1:0]                  take;
  logic [8:0]                     drop_sum;
  logic                           halt, capture, expired, handshake;

  cfi_log_compactor #(.NR_COMMIT_PORTS(NR_COMMIT_PORTS)) u_compactor (
    .logs        (log_i),
    .valid       (log_valid_i),
    .packed_logs (packed_logs),
    .count       (push_cnt)
  );

  // Halt depends only on the registered occupancy.
  assign halt      = (OW'(QUEUE_DEPTH) - occ) < OW'(NR_COMMIT_PORTS);
  assign halt_o    = halt;
  assign usage_o   = occ;
  assign take      = (occ >= OW'(BATCH_SIZE)) ? BW'(BATCH_SIZE) : BW'(occ);
  assign expired   = (FLUSH_TIMEOUT != 0) && (tcnt == TW'(FLUSH_TIMEOUT - 1));
  assign pushes    = halt ? '0 : OW'(push_cnt);
  assign pops      = capture ? OW'(take) : '0;
  assign handshake = (state == CFI_BATCH_PRESENT) && batch_ready_i;
  assign drop_sum  = {1'b0, drop_cnt_o} + 9'(push_cnt);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state <= CFI_BATCH_COLLECT;
    else       state <= state_next;
  end

  always_comb begin
    state_next    = state;
    capture       = 1'b0;
    batch_valid_o = 1'b0;
    case (state)
      CFI_BATCH_COLLECT: begin
        if (occ >= OW'(BATCH_SIZE) || (occ != '0 && (flush_i || expired))) begin
          capture    = 1'b1;
          state_next = CFI_BATCH_PRESENT;
        end
      end
      CFI_BATCH_PRESENT: begin
        batch_valid_o = 1'b1;
        if (handshake) state_next = CFI_BATCH_COLLECT;
      end
      default: state_next = CFI_BATCH_COLLECT;
    endcase
  end

  // Storage needs no reset: pointers and occupancy define what is live.
  always_ff @(posedge clk_i) begin
    for (int i = 0; i < int'(NR_COMMIT_PORTS); i++) begin
      if (!halt && i < int'(push_cnt)) q[wr_ptr + PW'(i)] <= packed_logs[i];
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      occ           <= '0;
      tcnt          <= '0;
      drop_cnt_o    <= '0;
      batch_count_o <= '0;
      batch_o       <= '0;
    end else begin
      wr_ptr <= wr_ptr + PW'(pushes);
      rd_ptr <= rd_ptr + PW'(pops);
      occ    <= occ + pushes - pops;

      if (capture || occ == '0)
        tcnt <= '0;
      else if (state == CFI_BATCH_COLLECT && occ < OW'(BATCH_SIZE) && !expired)
        tcnt <= tcnt + TW'(1);

      if (halt) drop_cnt_o <= drop_sum[8] ? 8'hff : drop_sum[7:0];

      if (capture) begin
        for (int j = 0; j < int'(BATCH_SIZE); j++)
          batch_o[j] <= (j < int'(take)) ? q[rd_ptr + PW'(j)] : cfi_log_t'('0);
        batch_count_o <= take;
      end
    end
  end

`ifdef CFI_BATCH_PERF_EN
  logic [31:0] perf_b, perf_p;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      perf_b <= '0;
      perf_p <= '0;
    end else if (handshake) begin
      perf_b <= perf_b + 32'd1;
      if (batch_count_o < BW'(BATCH_SIZE)) perf_p <= perf_p + 32'd1;
    end
  end

  assign perf_batches_o = perf_b;
  assign perf_partial_o = perf_p;
`else
  assign perf_batches_o = '0;
  assign perf_partial_o = '0;
`endif

endmodule

// File: tb/tb_cfi_log_batcher.sv
module tb_cfi_log_batcher;
  import cfi_log_batcher_pkg::*;

  localparam int NP = 2;
  localparam int QD = 8;
  localparam int BS = 4;
  localparam int FT = 64;

  logic                 clk, rst;
  cfi_log_t [NP-1:0]    log_in;
  logic     [NP-1:0]    valid;
  logic                 flush, ready;
  logic                 halt_o, batch_valid_o;
  cfi_log_t [BS-1:0]    batch_o;
  logic     [2:0]       batch_count_o;
  logic     [3:0]       usage_o;
  logic     [7:0]       drop_cnt_o;
  logic     [31:0]      perf_batches_o, perf_partial_o;

  int cmp_n = 0;
  int err_n = 0;

  // Reference model: a plain FIFO of accepted logs, the presented batch, and
  // the idle timer, all stepped once per clock edge from the specified rules.
  cfi_log_t mq[$];
  cfi_log_t mb[$];
  bit       m_present;
  int       m_timer, m_drop, m_perf_b, m_perf_p;

  cfi_log_batcher #(
    .NR_COMMIT_PORTS(NP), .QUEUE_DEPTH(QD), .BATCH_SIZE(BS), .FLUSH_TIMEOUT(FT)
  ) dut (
    .clk_i(clk), .rst_i(rst), .log_i(log_in), .log_valid_i(valid),
    .flush_i(flush), .halt_o(halt_o), .batch_o(batch_o),
    .batch_count_o(batch_count_o), .batch_valid_o(batch_valid_o),
    .batch_ready_i(ready), .usage_o(usage_o), .drop_cnt_o(drop_cnt_o),
    .perf_batches_o(perf_batches_o), .perf_partial_o(perf_partial_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic cfi_log_t rand_log();
    logic [95:0] r;
    r = {$urandom(), $urandom(), $urandom()};
    return r[$bits(cfi_log_t)-1:0];
  endfunction

  function automatic cfi_log_t [BS-1:0] exp_batch();
    cfi_log_t [BS-1:0] e;
    e = '0;
    for (int j = 0; j < BS; j++) if (j < mb.size()) e[j] = mb[j];
    return e;
  endfunction

  function automatic bit m_halt();
    return (QD - mq.size()) < NP;
  endfunction

  task automatic model_reset();
    mq.delete(); mb.delete();
    m_present = 0; m_timer = 0; m_drop = 0; m_perf_b = 0; m_perf_p = 0;
  endtask

  task automatic model_edge();
    int occ;
    bit h, expd;
    int n;
    occ = mq.size();
    h = m_halt();
    if (rst) begin
      model_reset();
      return;
    end
    if (!m_present) begin
      expd = (FT != 0) && (m_timer == FT - 1);
      if (occ >= BS || (occ > 0 && (flush || expd))) begin
        n = (occ < BS) ? occ : BS;
        mb.delete();
        repeat (n) mb.push_back(mq.pop_front());
        m_present = 1;
        m_timer = 0;
      end else if (occ == 0) m_timer = 0;
      else m_timer++;
    end else begin
      if (ready) begin
        m_present = 0;
        m_perf_b++;
        if (mb.size() < BS) m_perf_p++;
      end
      if (occ == 0) m_timer = 0;
    end
    for (int i = 0; i < NP; i++) begin
      if (valid[i]) begin
        if (!h) mq.push_back(log_in[i]);
        else if (m_drop < 255) m_drop++;
      end
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic test_reset();
    #2;
    cmp_n++; if (batch_valid_o !== 1'b0) begin err_n++; $display("FAIL reset_valid got %0b want 0", batch_valid_o); end
    cmp_n++; if (batch_count_o !== 3'd0) begin err_n++; $display("FAIL reset_count got %0d want 0", batch_count_o); end
    cmp_n++; if (usage_o !== 4'd0) begin err_n++; $display("FAIL reset_usage got %0d want 0", usage_o); end
    cmp_n++; if (halt_o !== 1'b0) begin err_n++; $display("FAIL reset_halt got %0b want 0", halt_o); end
    cmp_n++; if (drop_cnt_o !== 8'd0) begin err_n++; $display("FAIL reset_drop got %0d want 0", drop_cnt_o); end
    cmp_n++; if (batch_o !== '0) begin err_n++; $display("FAIL reset_batch got %h want 0", batch_o); end
    cmp_n++; if (perf_batches_o !== 32'd0 || perf_partial_o !== 32'd0) begin
      err_n++; $display("FAIL reset_perf got %0d/%0d want 0/0", perf_batches_o, perf_partial_o); end
    cyc();
    rst = 1'b0;
  endtask

  task automatic test_full_batch();
    cfi_log_t a [4];
    int lat;
    for (int i = 0; i < 4; i++) a[i] = rand_log();
    ready = 1'b1;
    valid = 2'b11; log_in[0] = a[0]; log_in[1] = a[1];
    cyc();
    log_in[0] = a[2]; log_in[1] = a[3];
    cyc();
    valid = 2'b00;
    lat = 0;
    while (!batch_valid_o && lat < 10) begin cyc(); lat++; end
    cmp_n++; if (lat !== 1) begin err_n++; $display("FAIL full_latency got %0d want 1", lat); end
    cmp_n++; if (batch_count_o !== 3'd4) begin err_n++; $display("FAIL full_count got %0d want 4", batch_count_o); end
    for (int i = 0; i < 4; i++) begin
      cmp_n++; if (batch_o[i] !== a[i]) begin err_n++; $display("FAIL full_entry%0d got %h want %h", i, batch_o[i], a[i]); end
    end
    cyc();
    cmp_n++; if (batch_valid_o !== 1'b0) begin err_n++; $display("FAIL full_valid_drop got %0b want 0", batch_valid_o); end
    cmp_n++; if (usage_o !== 4'd0) begin err_n++; $display("FAIL full_usage got %0d want 0", usage_o); end
  endtask

  task automatic test_compaction();
    cfi_log_t x, y0, y1;
    x = rand_log(); y0 = rand_log(); y1 = rand_log();
    valid = 2'b10; log_in[0] = rand_log(); log_in[1] = x;
    cyc();
    valid = 2'b11; log_in[0] = y0; log_in[1] = y1;
    cyc();
    valid = 2'b00; flush = 1'b1;
    cyc();
    flush = 1'b0;
    cmp_n++; if (batch_valid_o !== 1'b1) begin err_n++; $display("FAIL compact_valid got %0b want 1", batch_valid_o); end
    cmp_n++; if (batch_count_o !== 3'd3) begin err_n++; $display("FAIL compact_count got %0d want 3", batch_count_o); end
    cmp_n++; if (batch_o[0] !== x || batch_o[1] !== y0 || batch_o[2] !== y1 || batch_o[3] !== '0) begin
      err_n++; $display("FAIL compact_order got %h want %h %h %h 0", batch_o, x, y0, y1); end
    cyc();
  endtask

  task automatic test_timeout();
    cfi_log_t t;
    int lat;
    t = rand_log();
    valid = 2'b01; log_in[0] = t;
    cyc();
    valid = 2'b00;
    lat = 0;
    while (!batch_valid_o && lat < 200) begin cyc(); lat++; end
    cmp_n++; if (lat !== FT) begin err_n++; $display("FAIL timeout_latency got %0d want %0d", lat, FT); end
    cmp_n++; if (batch_count_o !== 3'd1) begin err_n++; $display("FAIL timeout_count got %0d want 1", batch_count_o); end
    cmp_n++; if (batch_o[0] !== t || batch_o[1] !== '0 || batch_o[2] !== '0 || batch_o[3] !== '0) begin
      err_n++; $display("FAIL timeout_slots got %h want %h,0,0,0", batch_o, t); end
    cyc();
`ifdef CFI_BATCH_PERF_EN
    cmp_n++; if (perf_partial_o !== 32'(m_perf_p) || perf_batches_o !== 32'(m_perf_b)) begin
      err_n++; $display("FAIL timeout_perf got %0d/%0d want %0d/%0d", perf_batches_o, perf_partial_o, m_perf_b, m_perf_p); end
`else
    cmp_n++; if (perf_partial_o !== 32'd0 || perf_batches_o !== 32'd0) begin
      err_n++; $display("FAIL timeout_perf got %0d/%0d want 0/0", perf_batches_o, perf_partial_o); end
`endif
  endtask

  task automatic test_halt();
    int k;
    ready = 1'b0;
    k = 0;
    while (usage_o != 4'd7 && k < 30) begin
      if (usage_o == 4'd6) begin
        cmp_n++; if (halt_o !== 1'b0) begin err_n++; $display("FAIL halt_at6 got %0b want 0", halt_o); end
      end
      valid = 2'b01; log_in[0] = rand_log();
      cyc(); k++;
    end
    valid = 2'b00;
    cmp_n++; if (usage_o !== 4'd7) begin err_n++; $display("FAIL halt_fill got %0d want 7", usage_o); end
    cmp_n++; if (halt_o !== 1'b1) begin err_n++; $display("FAIL halt_at7 got %0b want 1", halt_o); end
    valid = 2'b11; log_in[0] = rand_log(); log_in[1] = rand_log();
    cyc();
    valid = 2'b00;
    cmp_n++; if (drop_cnt_o !== 8'd2) begin err_n++; $display("FAIL halt_drop got %0d want 2", drop_cnt_o); end
    cmp_n++; if (usage_o !== 4'd7) begin err_n++; $display("FAIL halt_usage got %0d want 7", usage_o); end
  endtask

  task automatic test_backpressure_wrap();
    cfi_log_t [BS-1:0] sb;
    logic [2:0] sc;
    sb = batch_o; sc = batch_count_o;
    ready = 1'b0;
    for (int c = 0; c < 20; c++) begin
      valid = 2'($urandom()); log_in[0] = rand_log(); log_in[1] = rand_log();
      cyc();
      cmp_n++; if (batch_valid_o !== 1'b1 || batch_o !== sb || batch_count_o !== sc) begin
        err_n++; $display("FAIL hold_c%0d got v=%0b n=%0d %h want v=1 n=%0d %h", c, batch_valid_o, batch_count_o, batch_o, sc, sb); end
    end
    for (int c = 0; c < 400; c++) begin
      ready = ($urandom_range(0, 3) != 0);
      flush = ($urandom_range(0, 7) == 0);
      valid = 2'($urandom()); log_in[0] = rand_log(); log_in[1] = rand_log();
      cyc();
      cmp_n++; if (usage_o !== 4'(mq.size()) || halt_o !== m_halt() || batch_valid_o !== m_present || drop_cnt_o !== 8'(m_drop)) begin
        err_n++; $display("FAIL rand_c%0d got u=%0d h=%0b v=%0b d=%0d want u=%0d h=%0b v=%0b d=%0d", c,
          usage_o, halt_o, batch_valid_o, drop_cnt_o, mq.size(), m_halt(), m_present, m_drop); end
      if (m_present) begin
        cmp_n++; if (batch_count_o !== 3'(mb.size()) || batch_o !== exp_batch()) begin
          err_n++; $display("FAIL rand_batch_c%0d got n=%0d %h want n=%0d %h", c, batch_count_o, batch_o, mb.size(), exp_batch()); end
      end
    end
    flush = 1'b0; valid = 2'b00;
  endtask

  task automatic test_flush_reset();
    int k;
    ready = 1'b1; flush = 1'b1;
    k = 0;
    while ((usage_o != 4'd0 || batch_valid_o) && k < 50) begin cyc(); k++; end
    flush = 1'b0;
    cmp_n++; if (usage_o !== 4'd0 || batch_valid_o !== 1'b0) begin
      err_n++; $display("FAIL drain got u=%0d v=%0b want 0/0", usage_o, batch_valid_o); end
    valid = 2'b11; log_in[0] = rand_log(); log_in[1] = rand_log();
    cyc();
    valid = 2'b00; flush = 1'b1; ready = 1'b0;
    cyc();
    flush = 1'b0;
    cmp_n++; if (batch_valid_o !== 1'b1 || batch_count_o !== 3'd2) begin
      err_n++; $display("FAIL flush_count got v=%0b n=%0d want 1/2", batch_valid_o, batch_count_o); end
    valid = 2'b11; log_in[0] = rand_log(); log_in[1] = rand_log();
    cyc();
    valid = 2'b00;
    cmp_n++; if (usage_o !== 4'(mq.size()) || usage_o !== 4'd2) begin
      err_n++; $display("FAIL present_push got %0d want 2", usage_o); end
    #2 rst = 1'b1;
    #1;
    model_reset();
    cmp_n++; if (batch_valid_o !== 1'b0 || usage_o !== 4'd0) begin
      err_n++; $display("FAIL async_reset got v=%0b u=%0d want 0/0", batch_valid_o, usage_o); end
    cyc();
    cmp_n++; if (batch_valid_o !== 1'b0 || usage_o !== 4'd0 || batch_count_o !== 3'd0 || batch_o !== '0 || drop_cnt_o !== 8'd0) begin
      err_n++; $display("FAIL reset_clear got v=%0b u=%0d n=%0d d=%0d want all 0", batch_valid_o, usage_o, batch_count_o, drop_cnt_o); end
    rst = 1'b0; ready = 1'b1;
    cyc();
    cmp_n++; if (batch_valid_o !== 1'b0 || usage_o !== 4'd0) begin
      err_n++; $display("FAIL post_reset got v=%0b u=%0d want 0/0", batch_valid_o, usage_o); end
  endtask

  initial begin
    rst = 1'b1; valid = '0; flush = 1'b0; ready = 1'b0; log_in = '0;
    model_reset();
    test_reset();
    test_full_batch();
    test_compaction();
    test_timeout();
    test_halt();
    test_backpressure_wrap();
    test_flush_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_n, err_n);
    $finish;
  end

endmodule

// File: doc/cfi_log_batcher.md
Name: cfi_log_batcher

Overview:
- Parametrised successor to the single-entry CFI queue controller.
- Accepts up to NR_COMMIT_PORTS filtered CFI logs per cycle, compacts them into an internal circular queue, and emits them to the CFI backend in multi-entry batches over a valid/ready handshake.
- A batch is emitted when it is full, on idle timeout, or on explicit flush.
- Sits between cfi_filter and cfi_backend. Drives the commit-stage halt.

Parameters:
- NR_COMMIT_PORTS, 2, commit ports (log inputs) per cycle.
- QUEUE_DEPTH, 8, queue entries; power of two, >= NR_COMMIT_PORTS and >= BATCH_SIZE.
- BATCH_SIZE, 4, max logs per batch; 1..QUEUE_DEPTH.
- FLUSH_TIMEOUT, 64, idle cycles before a partial batch is emitted; 0 disables the timeout.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  asynchronous reset, active-high.
- log_i  in  NR_COMMIT_PORTS x cfi_log_t  filtered logs.
- log_valid_i  in  NR_COMMIT_PORTS  per-port log valid.
- flush_i  in  1  force emission of a partial batch.
- halt_o  out  1  stall commit; free slots < NR_COMMIT_PORTS.
- batch_o  out  BATCH_SIZE x cfi_log_t  batch payload; entry 0 is the oldest.
- batch_count_o  out  $clog2(BATCH_SIZE+1)  valid entries in batch_o.
- batch_valid_o  out  1  batch offered.
- batch_ready_i  in  1  backend accepts the batch.
- usage_o  out  $clog2(QUEUE_DEPTH+1)  queue occupancy.
- drop_cnt_o  out  8  saturating count of logs dropped while halted.
- perf_batches_o  out  32  perf: batches accepted.
- perf_partial_o  out  32  perf: partial batches accepted.

Behaviour:
Reset values:
- All outputs 0.
- Pointers 0, occupancy 0, FSM in COLLECT, timeout counter 0.
- batch_o cleared.
- Reset mid-batch discards queue and batch contents; no handshake completes.

Halt and push:
- halt_o is derived from registered occupancy only; there is no combinational path from log_valid_i.
- halt_o = (QUEUE_DEPTH - occ) < NR_COMMIT_PORTS.
- When halt_o=0, valid ports are compacted in ascending port order and written at wr_ptr, wr_ptr+1, ... modulo QUEUE_DEPTH.
- When halt_o=1, any asserted log_valid_i is dropped and drop_cnt_o increments by popcount, saturating at 255.

FSM COLLECT:
- Capture condition, evaluated on registered occ: occ >= BATCH_SIZE, or (occ>0 and flush_i), or (occ>0 and timeout expired).
- On capture, n = min(occ, BATCH_SIZE) oldest entries are copied into batch_o.
- Unused batch_o slots are set to 0.
- batch_count_o = n; rd_ptr advances by n; state goes to PRESENT.

FSM PRESENT:
- batch_valid_o=1.
- batch_o and batch_count_o are held stable until batch_ready_i.
- On handshake: state returns to COLLECT and batch_valid_o deasserts the next cycle.
- Pushes continue during PRESENT.

Latency:
- Logs pushed in cycle N are visible in occ at N+1.
- Earliest capture is at the N+1 edge; batch_valid_o is high in N+2.

Occupancy update:
- occ_next = occ + pushes - pops.
- Same-cycle push and capture are legal.
- Pointers wrap modulo QUEUE_DEPTH.

Timeout:
- The counter increments each cycle in COLLECT while 0 < occ < BATCH_SIZE.
- It clears on capture, or when occ==0.
- It expires when count == FLUSH_TIMEOUT-1.
- With FLUSH_TIMEOUT=0 it never expires.

Optional Feature:
- Macro CFI_BATCH_PERF_EN.
- Defined: two 32-bit wrapping counters, updated on each accepted handshake.
  - perf_batches_o counts every accepted batch.
  - perf_partial_o counts batches with batch_count_o < BATCH_SIZE.
- Undefined: counters are not instantiated; both ports are tied to 0.

Decomposition:
- ariane_pkg: cfi_log_t (existing), plus new typedef cfi_batch_state_e {CFI_BATCH_COLLECT, CFI_BATCH_PRESENT}.
- Sub-module cfi_log_compactor (combinational).
  - Inputs: log_i, log_valid_i.
  - Outputs: packed logs and push count.
- The queue storage, FSM and counters live in cfi_log_batcher.

Test Plan:
- Full batch: BATCH_SIZE=4, ports 0 and 1 valid for 2 cycles (logs A,B,C,D), ready held 1 -> batch_valid_o in cycle 3 with batch_o={A,B,C,D}, count=4; usage_o 0 after the handshake.
- Compaction: valid=2'b10 with log X, then 2'b11 with Y0,Y1 -> queue order X,Y0,Y1.
- Timeout: one log pushed, FLUSH_TIMEOUT=64, no further input -> partial batch emitted with count=1 and slots 1..3 zero; perf_partial_o=1 with CFI_BATCH_PERF_EN.
- Halt: QUEUE_DEPTH=8, ready=0, fill to 7 -> halt_o=1; drive valid=2'b11 anyway -> drop_cnt_o=2, usage_o unchanged.
- Backpressure and wrap: ready low for 20 cycles during PRESENT -> batch_o stable; after ready, 3 further batches cross the pointer wrap with order preserved.
- Flush and reset: flush_i with occ=2 -> count=2. Assert rst_i during PRESENT -> batch_valid_o=0, usage_o=0 next cycle.
